data_store_buffer: RTL and testbench

//  Sits between the pipeline's data-sram port (EXE issues en/wen/addr/wdata) and a variable-latency
//  req/addr_ok/data_ok data memory. Posts stores into an in-order FIFO so they retire without waiting
//  on memory. Issues loads only after the FIFO drains; stalls the pipeline via cpu_stall.

---
 rtl/data_store_buffer.sv | 180 ++++++++++++++++++
 tb/tb_data_store_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_store_buffer.sv
// Posted-store FIFO between the pipeline data port and a req/addr_ok/data_ok memory; loads wait for the drain.
// Define STORE_FWD_EN to let loads forward from a youngest full-word FIFO entry.
module data_store_buffer #(
    parameter int SB_DEPTH = 4,
    parameter int SB_PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_DATA,
        S_R_ADDR,
        S_R_DATA
    } state_t;

    state_t state_q, state_d;

    logic [31:0]         fifo_addr_q [SB_DEPTH];
    logic [3:0]          fifo_wen_q  [SB_DEPTH];
    logic [31:0]         fifo_data_q [SB_DEPTH];
    logic [SB_PTR_W-1:0] head_q, tail_q;
    logic [SB_PTR_W:0]   count_q;

    logic        rd_pend_q, rd_pend_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;

    logic fifo_empty, fifo_full;
    logic is_store, store_req, load_req, read_busy;
    logic push, pop, load_acc;
    logic fwd_ok;
    logic [31:0] fwd_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (SB_PTR_W+1)'(SB_DEPTH));
    assign is_store   = |cpu_wen;
    assign store_req  = cpu_en & is_store;
    assign load_req   = cpu_en & ~is_store;
    assign read_busy  = rd_pend_q | (state_q == S_R_ADDR) | (state_q == S_R_DATA);

`ifdef STORE_FWD_EN
    logic                fwd_hit, fwd_full;
    logic [SB_PTR_W-1:0] fwd_idx;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_full = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            fwd_idx = head_q + SB_PTR_W'(i);
            if (((SB_PTR_W+1)'(i) < count_q) &&
                (fifo_addr_q[fwd_idx][31:2] == cpu_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_full = (fifo_wen_q[fwd_idx] == 4'hf);
                fwd_data = fifo_data_q[fwd_idx];
            end
        end
    end

    // Forwarding is held off while a memory read is outstanding so responses stay ordered.
    assign fwd_ok = load_req & fwd_hit & fwd_full & ~read_busy;
`else
    assign fwd_ok   = 1'b0;
    assign fwd_data = '0;
`endif

    always_comb begin
        cpu_stall = 1'b0;
        if (store_req) begin
            cpu_stall = fifo_full;
        end else if (load_req && !fwd_ok) begin
            cpu_stall = ~fifo_empty | (state_q != S_IDLE) | rd_pend_q;
        end
    end

    assign push     = store_req & ~cpu_stall;
    assign load_acc = load_req & ~cpu_stall & ~fwd_ok;
    assign pop      = (state_q == S_W_ADDR) & mem_addr_ok;

    always_comb begin
        state_d      = state_q;
        rd_pend_d    = rd_pend_q | load_acc;
        rd_addr_d    = load_acc ? cpu_addr : rd_addr_q;
        cpu_rvalid_d = fwd_ok;
        cpu_rdata_d  = fwd_ok ? fwd_data : cpu_rdata_q;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wstrb    = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        unique case (state_q)
            S_IDLE: begin
                // A load accepted this cycle is consumed immediately so mem_req rises the next cycle.
                if (rd_pend_d) begin
                    state_d   = S_R_ADDR;
                    rd_pend_d = 1'b0;
                end else if (!fifo_empty) begin
                    state_d = S_W_ADDR;
                end
            end
            S_W_ADDR: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_wstrb = fifo_wen_q[head_q];
                mem_addr  = fifo_addr_q[head_q];
                mem_wdata = fifo_data_q[head_q];
                if (mem_addr_ok) state_d = S_W_DATA;
            end
            S_W_DATA: begin
                if (mem_data_ok) state_d = S_IDLE;
            end
            S_R_ADDR: begin
                mem_req  = 1'b1;
                mem_addr = rd_addr_q;
                if (mem_addr_ok) state_d = S_R_DATA;
            end
            S_R_DATA: begin
                if (mem_data_ok) begin
                    cpu_rvalid_d = 1'b1;
                    cpu_rdata_d  = mem_rdata;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            if (push) begin
                fifo_addr_q[tail_q] <= cpu_addr;
                fifo_wen_q[tail_q]  <= cpu_wen;
                fifo_data_q[tail_q] <= cpu_wdata;
                tail_q              <= tail_q + 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_data_store_buffer.sv
// Scoreboard bench for data_store_buffer: expected memory requests and load data are queued by the
// stimulus and popped by a monitor; a small variable-latency memory model answers mem_req.
module tb_data_store_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b0;
    logic [3:0]  cpu_wen = '0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    data_store_buffer #(.SB_DEPTH(4), .SB_PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } mreq_t;

    int total = 0;
    int bad = 0;
    mreq_t       exp_mem[$];
    logic [31:0] exp_rd[$];

    logic [31:0] mem [bit [31:0]];
    int addr_lat = 0;
    int data_lat = 1;
    bit hold_addr = 1'b0;
    int n_acc = 0;
    int n_dok = 0;
    bit dbusy = 1'b0;
    int dcnt = 0;
    int cnt = 0;
    bit req_seen = 1'b0;
    mreq_t cur, seen;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic mreq_t live_req();
        mreq_t r;
        r.wr   = mem_wr;
        r.addr = mem_addr;
        r.strb = mem_wstrb;
        r.data = mem_wr ? mem_wdata : 32'h0;
        return r;
    endfunction

    // Memory model: addr_ok after addr_lat waiting cycles (unless held), data_ok data_lat cycles later.
    initial begin
        logic [31:0] w;
        forever begin
            @(posedge clk);
            #1;
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            if (reset) begin
                dbusy = 1'b0;
                req_seen = 1'b0;
                cnt = 0;
                continue;
            end
            if (dbusy) begin
                if (dcnt <= 1) begin
                    mem_data_ok = 1'b1;
                    dbusy = 1'b0;
                    n_dok++;
                    if (cur.wr) begin
                        w = mem_rd(cur.addr);
                        for (int b = 0; b < 4; b++)
                            if (cur.strb[b]) w[8*b +: 8] = cur.data[8*b +: 8];
                        mem[cur.addr] = w;
                    end else begin
                        mem_rdata = mem_rd(cur.addr);
                    end
                end else begin
                    dcnt--;
                end
            end
            if (mem_req) begin
                if (!req_seen) begin
                    seen = live_req();
                    req_seen = 1'b1;
                    cnt = 0;
                end else begin
                    check("req_stable", live_req(), seen);
                end
                if (!hold_addr && cnt >= addr_lat) begin
                    mem_addr_ok = 1'b1;
                    n_acc++;
                    cur = live_req();
                    dbusy = 1'b1;
                    dcnt = data_lat;
                    req_seen = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: every accepted memory request and every cpu_rvalid pops one expectation.
    initial begin
        mreq_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_req && mem_addr_ok) begin
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected", live_req(), 69'h0);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_req", live_req(), e);
                    end
                end
                if (cpu_rvalid) begin
                    if (exp_rd.size() == 0) begin
                        check("rvalid_unexpected", 69'(cpu_rdata), 69'h0 - 1);
                    end else begin
                        check("rdata", 69'(cpu_rdata), 69'(exp_rd.pop_front()));
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data,
                          output int stalls, output int acc_at);
        cpu_en = 1'b1;
        cpu_wen = wen;
        cpu_addr = addr;
        cpu_wdata = data;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!cpu_stall) break;
            stalls++;
            if (stalls >= 300) begin
                total++;
                bad++;
                $display("FAIL req_timeout: stalled %0d cycles, required acceptance", stalls);
                break;
            end
        end
        acc_at = n_acc;
        @(posedge clk);
        #1;
        cpu_en = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (k < 300 && !(exp_mem.size() == 0 && exp_rd.size() == 0 && !dbusy && !mem_req)) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_idle: pending mem=%0d rd=%0d, required 0", exp_mem.size(), exp_rd.size());
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int st, na, base_acc, base_dok;
        mem[32'h40] = 32'h12345678;

        // 1: reset held with cpu_en asserted
        cpu_en = 1'b1;
        cpu_wen = 4'h0;
        cpu_addr = 32'h40;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_mem_req", 69'(mem_req), 69'h0);
            check("rst_rvalid", 69'(cpu_rvalid), 69'h0);
            check("rst_rdata", 69'(cpu_rdata), 69'h0);
            check("rst_stall_load", 69'(cpu_stall), 69'h0);
            cpu_wen = 4'hf;
            #1;
            check("rst_stall_store", 69'(cpu_stall), 69'h0);
            cpu_wen = 4'h0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_en = 1'b0;
        @(posedge clk);
        #1;

        // 2: single store, addr_ok after 2 wait cycles, data_ok one later
        addr_lat = 2;
        data_lat = 1;
        base_acc = n_acc;
        exp_mem.push_back('{1'b1, 32'h100, 4'hf, 32'hDEADBEEF});
        do_req(4'hf, 32'h100, 32'hDEADBEEF, st, na);
        check("t2_stall", 69'(st), 69'h0);
        wait_idle();
        check("t2_one_write", 69'(n_acc - base_acc), 69'h1);
        check("t2_mem", 69'(mem_rd(32'h100)), 69'hDEADBEEF);

        // 3: five back-to-back stores with addr_ok held low
        addr_lat = 0;
        hold_addr = 1'b1;
        base_acc = n_acc;
        for (int i = 0; i < 4; i++) begin
            exp_mem.push_back('{1'b1, 32'h10 + 32'(4*i), 4'hf, 32'h1000 + 32'(i)});
            do_req(4'hf, 32'h10 + 32'(4*i), 32'h1000 + 32'(i), st, na);
            check("t3_no_stall", 69'(st), 69'h0);
        end
        exp_mem.push_back('{1'b1, 32'h20, 4'hf, 32'h1004});
        fork
            do_req(4'hf, 32'h20, 32'h1004, st, na);
            begin
                repeat (6) @(negedge clk);
                hold_addr = 1'b0;
            end
        join
        check("t3_5th_stalled", 69'(st > 0), 69'h1);
        check("t3_5th_after_pop", 69'(na - base_acc), 69'h1);
        wait_idle();
        check("t3_mem_last", 69'(mem_rd(32'h20)), 69'h1004);

        // 4: store then load of the same word, data_ok latency 3
        data_lat = 3;
        base_dok = n_dok;
        exp_mem.push_back('{1'b1, 32'h200, 4'hf, 32'hCAFEF00D});
        do_req(4'hf, 32'h200, 32'hCAFEF00D, st, na);
        exp_rd.push_back(32'hCAFEF00D);
`ifdef STORE_FWD_EN
        do_req(4'h0, 32'h200, 32'h0, st, na);
        check("t4_fwd_no_stall", 69'(st), 69'h0);
`else
        exp_mem.push_back('{1'b0, 32'h200, 4'h0, 32'h0});
        do_req(4'h0, 32'h200, 32'h0, st, na);
        check("t4_load_stalled", 69'(st > 0), 69'h1);
        check("t4_after_wdone", 69'(n_dok - base_dok), 69'h1);
`endif
        wait_idle();

        // 5: load latency with zero-wait addr_ok and data_ok the next cycle
        data_lat = 1;
        exp_mem.push_back('{1'b0, 32'h40, 4'h0, 32'h0});
        exp_rd.push_back(32'h12345678);
        cpu_en = 1'b1;
        cpu_wen = 4'h0;
        cpu_addr = 32'h40;
        @(negedge clk);
        check("t5_stall_T", 69'(cpu_stall), 69'h0);
        @(posedge clk);
        #1;
        cpu_en = 1'b0;
        @(negedge clk);
        check("t5_req_T1", 69'(mem_req), 69'h1);
        check("t5_rvalid_T1", 69'(cpu_rvalid), 69'h0);
        @(negedge clk);
        check("t5_rvalid_T2", 69'(cpu_rvalid), 69'h0);
        @(negedge clk);
        check("t5_rvalid_T3", 69'(cpu_rvalid), 69'h1);
        @(negedge clk);
        check("t5_rvalid_T4", 69'(cpu_rvalid), 69'h0);
        check("t5_rdata_held", 69'(cpu_rdata), 69'h12345678);
        @(posedge clk);
        #1;
        wait_idle();

`ifdef STORE_FWD_EN
        // 6a: full-word forward while the store is still queued
        hold_addr = 1'b1;
        exp_mem.push_back('{1'b1, 32'h300, 4'hf, 32'hA5A5A5A5});
        do_req(4'hf, 32'h300, 32'hA5A5A5A5, st, na);
        exp_rd.push_back(32'hA5A5A5A5);
        cpu_en = 1'b1;
        cpu_wen = 4'h0;
        cpu_addr = 32'h300;
        @(negedge clk);
        check("t6_fwd_stall", 69'(cpu_stall), 69'h0);
        @(posedge clk);
        #1;
        cpu_en = 1'b0;
        @(negedge clk);
        check("t6_fwd_rvalid", 69'(cpu_rvalid), 69'h1);
        hold_addr = 1'b0;
        wait_idle();
        check("t6_mem_full", 69'(mem_rd(32'h300)), 69'hA5A5A5A5);

        // 6b: partial store blocks forwarding; load reads the merged word after the drain
        hold_addr = 1'b1;
        base_dok = n_dok;
        exp_mem.push_back('{1'b1, 32'h300, 4'h3, 32'h11112222});
        do_req(4'h3, 32'h300, 32'h11112222, st, na);
        exp_mem.push_back('{1'b0, 32'h300, 4'h0, 32'h0});
        exp_rd.push_back(32'hA5A52222);
        fork
            do_req(4'h0, 32'h300, 32'h0, st, na);
            begin
                repeat (4) @(negedge clk);
                hold_addr = 1'b0;
            end
        join
        check("t6_partial_stalled", 69'(st > 0), 69'h1);
        check("t6_after_wdone", 69'(n_dok - base_dok), 69'h1);
        wait_idle();
`endif

        check("exp_mem_drained", 69'(exp_mem.size()), 69'h0);
        check("exp_rd_drained", 69'(exp_rd.size()), 69'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
